// File: rtl/fft8_pkg.sv
// fft8_pkg
//   Constants and helpers shared by the 8-point FFT blocks (input loader and
//   the stage1/stage2/stage3 butterfly blocks).
//   DATA_W : sample width, one IEEE-754 single-precision real value
//   N      : FFT length
//   LOG2N  : index width for a sample position within a frame
//   bitrev3: 3-bit bit reversal used to reorder a natural-order frame
package fft8_pkg;

  localparam int DATA_W = 32;
  localparam int N      = 8;
  localparam int LOG2N  = 3;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/fft8_input_loader.sv
// fft8_input_loader
//   Collects natural-order samples s0..s7 into one of two ping-pong banks and
//   presents a completed frame in bit-reversed order to FFT stage 1.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     in_valid/in_ready     : sample handshake; in_ready comes from flops only
//     in_data, in_last      : sample, and end-of-frame marker on s7
//     out_valid/out_ready   : frame handshake toward stage 1
//     br0..br7              : frame in bit-reversed order (s0,s4,s2,s6,s1,s5,s3,s7)
//     err                   : one-cycle pulse when in_last disagrees with s7
module fft8_input_loader
  import fft8_pkg::N;
  import fft8_pkg::LOG2N;
  import fft8_pkg::bitrev3;
#(
  parameter int DATA_W = fft8_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] br0,
  output logic [DATA_W-1:0] br1,
  output logic [DATA_W-1:0] br2,
  output logic [DATA_W-1:0] br3,
  output logic [DATA_W-1:0] br4,
  output logic [DATA_W-1:0] br5,
  output logic [DATA_W-1:0] br6,
  output logic [DATA_W-1:0] br7,
  output logic              err
);

  localparam logic [LOG2N-1:0] LAST_PTR = LOG2N'(N - 1);

  logic [DATA_W-1:0] bank_q [2][N];
  logic [DATA_W-1:0] bank_d [2][N];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [1:0]        full_q,    full_d;
  logic              err_q,     err_d;

  logic accept;
  logic pop;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign err       = err_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;
    err_d     = 1'b0;

    if (accept) begin
      bank_d[wr_bank_q][wr_ptr_q] = in_data;
      if (wr_ptr_q == LAST_PTR) begin
        // Eighth sample always closes the frame; a missing in_last is only flagged.
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_ptr_d          = '0;
        err_d             = ~in_last;
      end else if (in_last) begin
        // Early in_last: drop the partial frame, reuse the same bank.
        wr_ptr_d = '0;
        err_d    = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // A pop always targets the other bank from a completing write (the write
    // bank is not full, the read bank is), so both updates can coexist.
    if (pop) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      full_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  assign br0 = bank_q[rd_bank_q][bitrev3(3'd0)];
  assign br1 = bank_q[rd_bank_q][bitrev3(3'd1)];
  assign br2 = bank_q[rd_bank_q][bitrev3(3'd2)];
  assign br3 = bank_q[rd_bank_q][bitrev3(3'd3)];
  assign br4 = bank_q[rd_bank_q][bitrev3(3'd4)];
  assign br5 = bank_q[rd_bank_q][bitrev3(3'd5)];
  assign br6 = bank_q[rd_bank_q][bitrev3(3'd6)];
  assign br7 = bank_q[rd_bank_q][bitrev3(3'd7)];

endmodule

// File: tb/tb_fft8_input_loader.sv
// tb_fft8_input_loader
//   Directed and randomized stimulus for fft8_input_loader, checked every
//   cycle against a frame-level reference model (queue of pending frames).
module tb_fft8_input_loader;

  typedef logic [7:0][31:0] frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] br0, br1, br2, br3, br4, br5, br6, br7;
  logic        err;

  fft8_input_loader #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .br0(br0), .br1(br1), .br2(br2), .br3(br3),
    .br4(br4), .br5(br5), .br6(br6), .br7(br7),
    .err(err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] cur_q[$];     // samples of the frame being assembled
  frame_t      exp_q[$];     // completed frames not yet taken downstream
  logic        exp_err;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_accepts = 0;
  int          n_pops    = 0;
  int          n_errs    = 0;

  function automatic frame_t make_frame(input logic [31:0] s0, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] s3,
                                        input logic [31:0] s4, input logic [31:0] s5,
                                        input logic [31:0] s6, input logic [31:0] s7);
    logic [31:0] s [8];
    frame_t f;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    s[4] = s4; s[5] = s5; s[6] = s6; s[7] = s7;
    for (int k = 0; k < 8; k++) begin
      // output position k holds the sample whose 3-bit index is k reversed
      f[k] = s[((k % 2) * 4) + (((k / 2) % 2) * 2) + (k / 4)];
    end
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    frame_t f;
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      check("br0", br0, f[0]); check("br1", br1, f[1]);
      check("br2", br2, f[2]); check("br3", br3, f[3]);
      check("br4", br4, f[4]); check("br5", br5, f[5]);
      check("br6", br6, f[6]); check("br7", br7, f[7]);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model, check.
  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic ordy);
    logic acc, pop;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    acc = v && (exp_q.size() < 2);
    pop = ordy && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (pop) begin
      void'(exp_q.pop_front());
      n_pops++;
    end
    if (acc) begin
      n_accepts++;
      cur_q.push_back(d);
      if (cur_q.size() == 8) begin
        exp_q.push_back(make_frame(cur_q[0], cur_q[1], cur_q[2], cur_q[3],
                                   cur_q[4], cur_q[5], cur_q[6], cur_q[7]));
        exp_err = !l;
        cur_q.delete();
      end else if (l) begin
        exp_err = 1'b1;
        cur_q.delete();
      end
    end
    if (exp_err) n_errs++;
    check_outputs();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur_q.delete();
    exp_q.delete();
    exp_err = 1'b0;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst br0", br0, 32'd0);
    check("rst br7", br7, 32'd0);
  endtask

  initial begin
    int a0, p0, e0;
    logic [31:0] r;

    exp_err = 1'b0;
    do_reset();

    // Directed frame 40E00000+k, back to back
    for (int k = 0; k < 8; k++) step(1'b1, 32'h40E00000 + k, k == 7, 1'b0);
    check("dir out_valid", {31'd0, out_valid}, 32'd1);
    check("dir br0", br0, 32'h40E00000); check("dir br1", br1, 32'h40E00004);
    check("dir br2", br2, 32'h40E00002); check("dir br3", br3, 32'h40E00006);
    check("dir br4", br4, 32'h40E00001); check("dir br5", br5, 32'h40E00005);
    check("dir br6", br6, 32'h40E00003); check("dir br7", br7, 32'h40E00007);
    step(1'b0, '0, 1'b0, 1'b1);
    check("dir popped", {31'd0, out_valid}, 32'd0);

    // Backpressure: 20 samples offered with out_ready low
    a0 = n_accepts;
    for (int k = 0; k < 20; k++) step(1'b1, $urandom, (k % 8) == 7, 1'b0);
    check("bp accepts", n_accepts - a0, 32'd16);
    check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    p0 = n_pops;
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, 1'b1);
    check("bp drained", n_pops - p0, 32'd2);

    // Early in_last on the 5th sample, then a good frame
    e0 = n_errs;
    for (int k = 0; k < 5; k++) step(1'b1, $urandom, k == 4, 1'b1);
    check("early err count", n_errs - e0, 32'd1);
    check("early no frame", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 8; k++) step(1'b1, $urandom, k == 7, 1'b0);
    check("after early frame", {31'd0, out_valid}, 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Missing in_last: frame still delivered, err on s7
    e0 = n_errs;
    for (int k = 0; k < 8; k++) step(1'b1, $urandom, 1'b0, 1'b0);
    check("nolast err count", n_errs - e0, 32'd1);
    check("nolast frame", {31'd0, out_valid}, 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Reset after 3 samples drops them
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 32'hA0000000 + k, k == 7, 1'b0);
    check("post-rst br0", br0, 32'hA0000000);
    check("post-rst br1", br1, 32'hA0000004);
    step(1'b0, '0, 1'b0, 1'b1);

    // Streaming 64 samples with out_ready held high
    a0 = n_accepts;
    p0 = n_pops;
    for (int k = 0; k < 64; k++) begin
      r = $urandom;
      step(1'b1, r, (k % 8) == 7, 1'b1);
    end
    check("stream accepts", n_accepts - a0, 32'd64);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("stream frames", n_pops - p0, 32'd8);

    // Random mix of valid, last and out_ready
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
